// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer.
// Owns the architectural HI/LO registers.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state;
  logic [2:0]       nxt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] opd;
  logic [W2-1:0]    acc;
  logic             neg_q;
  logic             neg_r;
  logic [CW-1:0]    cnt;
  logic             dz_r;

  logic             is_div;
  logic             is_sgn;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   msum;
  logic [W2-1:0]    mul_nxt;
  logic [WIDTH:0]   sr;
  logic [WIDTH+1:0] diff;
  logic [W2-1:0]    div_nxt;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] fq;
  logic [WIDTH-1:0] fr;
  logic             dz_c;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  assign is_div = op_r[1];
  assign is_sgn = ~op_r[0];

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign dz   = dz_r;

  // Operand magnitudes, one iteration step and the final sign fix-up.
  always_comb begin
    abs_a = (is_sgn && a_r[WIDTH-1]) ? -a_r : a_r;
    abs_b = (is_sgn && b_r[WIDTH-1]) ? -b_r : b_r;
    msum = {1'b0, acc[W2-1:WIDTH]}
         + {1'b0, (acc[0] ? opd : {WIDTH{1'b0}})};
    mul_nxt = {msum, acc[WIDTH-1:1]};
    sr = acc[W2-1:WIDTH-1];
    diff = {1'b0, sr} - {2'b00, opd};
    if (diff[WIDTH+1])
      div_nxt = {sr[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod = neg_q ? -acc : acc;
    fq = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    fr = neg_r ? -acc[W2-1:WIDTH] : acc[W2-1:WIDTH];
    dz_c = is_div && (b_r == {WIDTH{1'b0}});
    res_hi = prod[W2-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      if (dz_c) begin
        res_hi = a_r;
        res_lo = {WIDTH{1'b1}};
      end else begin
        res_hi = fr;
        res_lo = fq;
      end
    end
  end

  // Sequencer next-state; latency is fixed regardless of operands.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (start) nxt = S_PREP;
      S_PREP: nxt = S_CALC;
      S_CALC: if (cnt == CW'(1)) nxt = S_FIX;
      S_FIX:  nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= nxt;
  end

  // Working registers: capture, prepare, iterate, flag divide by zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_r  <= 2'b00;
      a_r   <= '0;
      b_r   <= '0;
      opd   <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
      dz_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r <= op;
            a_r  <= a;
            b_r  <= b;
          end
        end
        S_PREP: begin
          neg_q <= is_sgn & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
          neg_r <= is_sgn & a_r[WIDTH-1];
          opd   <= is_div ? abs_b : abs_a;
          acc   <= {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
          cnt   <= CW'(WIDTH);
        end
        S_CALC: begin
          acc <= is_div ? div_nxt : mul_nxt;
          cnt <= cnt - CW'(1);
        end
        S_FIX:  dz_r <= dz_c;
        S_DONE: dz_r <= 1'b0;
        default: dz_r <= 1'b0;
      endcase
    end
  end

  // HI/LO: moves while idle, results on the FIX->DONE edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (state == S_IDLE) begin
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed test of the mul/div sequencer.
// Hand-computed results, latency and handshake cases.
module tb_muldiv_seq;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_assert = 0;
  int n_fail   = 0;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op),
    .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller is 1ns after an edge with the DUT idle; that is cycle 0.
  task automatic run(input logic [1:0] o,
                     input logic [31:0] av,
                     input logic [31:0] bv,
                     input logic [31:0] ehi,
                     input logic [31:0] elo,
                     input logic edz,
                     input int inj,
                     input logic ist,
                     input logic imt,
                     input string tag);
    int dcyc = -1;
    int ndone = 0;
    logic bok = 1'b1;
    logic dzx = 1'b0;
    logic stab = 1'b1;
    logic dzd = 1'b0;
    logic [31:0] h0 = '0;
    logic [31:0] l0 = '0;
    logic [31:0] hd = '0;
    logic [31:0] ld = '0;
    op = o; a = av; b = bv; start = 1'b1;
    for (int n = 1; n <= 37; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      mtlo = 1'b0;
      if (busy !== (n <= 35)) bok = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (dcyc < 0) dcyc = n;
        hd = hi; ld = lo; dzd = dz;
      end else if (dz !== 1'b0) begin
        dzx = 1'b1;
      end
      if (n == 1) begin h0 = hi; l0 = lo; end
      else if (n <= 34 && (hi !== h0 || lo !== l0)) stab = 1'b0;
      if (n == inj) begin
        start = ist; mtlo = imt; wdata = 32'hDEAD_BEEF;
      end
    end
    check({tag, " done_cycle"}, 64'(dcyc), 64'd35);
    check({tag, " done_count"}, 64'(ndone), 64'd1);
    check({tag, " busy_window"}, 64'(bok), 64'd1);
    check({tag, " hilo_stable"}, 64'(stab), 64'd1);
    check({tag, " hi"}, 64'(hd), 64'(ehi));
    check({tag, " lo"}, 64'(ld), 64'(elo));
    check({tag, " dz"}, 64'(dzd), 64'(edz));
    check({tag, " dz_outside"}, 64'(dzx), 64'd0);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; op = 2'b00;
    a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst dz", 64'(dz), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 1'b0, 1'b0, "multu_max");
    run(2'b00, 32'hFFFF_FFFD, 32'd7,
        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 1'b0, 1'b0, "mult_neg");
    run(2'b10, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 1'b0, 1'b0, "div_neg");
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h0, 32'h8000_0000, 1'b0, 0, 1'b0, 1'b0, "div_wrap");
    run(2'b11, 32'd100, 32'd7,
        32'd2, 32'd14, 1'b0, 0, 1'b0, 1'b0, "divu");
    run(2'b11, 32'd5, 32'd0,
        32'd5, 32'hFFFF_FFFF, 1'b1, 0, 1'b0, 1'b0, "divu_dz");

    mthi = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    mthi = 1'b0;
    check("mthi hi", 64'(hi), 64'h1234);
    check("mthi lo_kept", 64'(lo), 64'hFFFF_FFFF);
    mtlo = 1'b1; wdata = 32'h0000_5678;
    @(posedge clk); #1;
    mtlo = 1'b0;
    check("mtlo lo", 64'(lo), 64'h5678);
    check("mtlo hi_kept", 64'(hi), 64'h1234);

    run(2'b00, 32'd100, 32'hFFFF_FFFB,
        32'hFFFF_FFFF, 32'hFFFF_FE0C, 1'b0, 10, 1'b1, 1'b1, "mult_inj");
    run(2'b11, 32'd100, 32'd7,
        32'd2, 32'd14, 1'b0, 35, 1'b1, 1'b0, "start_in_done");

    op = 2'b10; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("pre_rst busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    #1;
    check("mid_rst busy", 64'(busy), 64'd0);
    check("mid_rst done", 64'(done), 64'd0);
    check("mid_rst hi", 64'(hi), 64'd0);
    check("mid_rst lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    run(2'b01, 32'd6, 32'd7,
        32'd0, 32'd42, 1'b0, 0, 1'b0, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
